// File: rtl/globals_sv.sv
// rtl/globals_sv.sv - shared parameters, derived widths and FSM state type for the ofmap writer
package globals_sv;

  // Row width (elements per PE-array row), output bits per element, headroom bits
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int BG = 6;

  // Per-layer tiling: T tiles per side, C channels
  localparam int C1_NB_TILE  = 4;
  localparam int C1_NB_TILEC = 6;
  localparam int C2_NB_TILE  = 2;
  localparam int C2_NB_TILEC = 8;

  // Largest layer sizes the address space must cover
  localparam int NB_TILE  = C1_NB_TILE;
  localparam int NB_TILEC = C1_NB_TILEC;
  localparam int MAX_TILEC = (C1_NB_TILEC > C2_NB_TILEC) ? C1_NB_TILEC : C2_NB_TILEC;

  // Derived widths
  localparam int ACC_W   = N + BG;
  localparam int MEM_DW  = 2 * W * N;
  localparam int WADDR_W = $clog2(NB_TILE * NB_TILE * NB_TILEC * W / 2);
  localparam int ROW_W   = W * N;
  localparam int ROW_CW  = $clog2(W);
  localparam int TILE_CW = $clog2(NB_TILE);
  localparam int CH_CW   = $clog2(MAX_TILEC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ofmap_state_t;

  // Last tile index for the selected layer
  function automatic logic [TILE_CW-1:0] tile_last(input logic sel);
    return sel ? TILE_CW'(C2_NB_TILE - 1) : TILE_CW'(C1_NB_TILE - 1);
  endfunction

  // Last channel index for the selected layer
  function automatic logic [CH_CW-1:0] chan_last(input logic sel);
    return sel ? CH_CW'(C2_NB_TILEC - 1) : CH_CW'(C1_NB_TILEC - 1);
  endfunction

endpackage

// File: rtl/ofmap_quant.sv
// rtl/ofmap_quant.sv - per-element arithmetic shift, ReLU and unsigned saturation
module ofmap_quant
  import globals_sv::*;
(
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [2:0]       shamt,
  output logic        [N-1:0]     q
);

  localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((1 << N) - 1);

  logic signed [ACC_W-1:0] shifted;

  // Scale down, clip negatives to zero and large values to the top code
  always_comb begin
    shifted = acc >>> shamt;
    if (shifted < 0) begin
      q = '0;
    end else if (shifted > QMAX) begin
      q = {N{1'b1}};
    end else begin
      q = shifted[N-1:0];
    end
  end

endmodule

// File: rtl/ofmap_writer.sv
// rtl/ofmap_writer.sv - quantizes PE-array rows and packs row pairs into activation memory words
module ofmap_writer
  import globals_sv::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 layer_sel,
  input  logic [2:0]           shamt,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*ACC_W-1:0]   in_data,
  output logic                 mem_we,
  output logic [WADDR_W-1:0]   mem_addr,
  output logic [MEM_DW-1:0]    mem_wdata,
  output logic                 busy,
  output logic                 done
);

  ofmap_state_t         state;
  logic                 sel_q;
  logic [2:0]           shamt_q;
  logic [ROW_CW-1:0]    r;
  logic [TILE_CW-1:0]   tile_x;
  logic [TILE_CW-1:0]   tile_y;
  logic [CH_CW-1:0]     ch;
  logic [ROW_W-1:0]     pack;

  logic [ROW_W-1:0]     quant_row;
  logic [TILE_CW-1:0]   t_last;
  logic [CH_CW-1:0]     c_last;
  logic [WADDR_W-1:0]   t_num;
  logic [WADDR_W-1:0]   word_addr;
  logic                 last_row;
  logic                 fire;

  // One quantizer per element of the row, driven by the shift captured at start
  for (genvar i = 0; i < W; i++) begin : g_quant
    ofmap_quant u_quant (
      .acc   (in_data[i*ACC_W +: ACC_W]),
      .shamt (shamt_q),
      .q     (quant_row[i*N +: N])
    );
  end

  // Layer geometry, word address of the current odd row and end-of-layer detect
  always_comb begin
    t_last    = tile_last(sel_q);
    c_last    = chan_last(sel_q);
    t_num     = sel_q ? WADDR_W'(C2_NB_TILE) : WADDR_W'(C1_NB_TILE);
    word_addr = ((WADDR_W'(ch) * t_num + WADDR_W'(tile_y)) * t_num + WADDR_W'(tile_x))
                * WADDR_W'(W / 2) + WADDR_W'(r >> 1);
    last_row  = (r == ROW_CW'(W - 1)) && (tile_x == t_last) &&
                (tile_y == t_last) && (ch == c_last);
    fire      = in_ready && in_valid;
  end

  // Control FSM: counters, pack register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      shamt_q   <= '0;
      r         <= '0;
      tile_x    <= '0;
      tile_y    <= '0;
      ch        <= '0;
      pack      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_q    <= layer_sel;
            shamt_q  <= shamt;
            r        <= '0;
            tile_x   <= '0;
            tile_y   <= '0;
            ch       <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            // Even rows wait in the pack register for their odd partner
            if (!r[0]) begin
              pack <= quant_row;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= word_addr;
              mem_wdata <= {quant_row, pack};
            end
            // Row fastest, then tile_x, tile_y, channel
            if (r == ROW_CW'(W - 1)) begin
              r <= '0;
              if (tile_x == t_last) begin
                tile_x <= '0;
                if (tile_y == t_last) begin
                  tile_y <= '0;
                  if (ch == c_last) begin
                    ch <= '0;
                  end else begin
                    ch <= ch + 1'b1;
                  end
                end else begin
                  tile_y <= tile_y + 1'b1;
                end
              end else begin
                tile_x <= tile_x + 1'b1;
              end
            end else begin
              r <= r + 1'b1;
            end
            if (last_row) begin
              in_ready <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ofmap_writer.md
OFMAP_WRITER -- requirements
Module: ofmap_writer

Interface
REQ-001 SHALL use globals_sv parameters W=8, N=2, BG=6, NB_TILE, NB_TILEC; no module parameters beyond package values.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports listed first:
 clk        in   1              clock, rising edge
 rst        in   1              asynchronous active-high reset
REQ-003 SHALL expose the remaining ports:
 start      in   1              pulse, begin writing one layer output feature map
 layer_sel  in   1              0 = C1 (T=C1_NB_TILE, C=C1_NB_TILEC), 1 = C2 (T=C2_NB_TILE, C=C2_NB_TILEC)
 shamt      in   3              arithmetic right shift applied before saturation, 0..BG
 in_valid   in   1              PE-array output row valid
 in_ready   out  1              row accepted when in_valid & in_ready
 in_data    in   W*ACC_W        W signed accumulators, element i at [i*ACC_W +: ACC_W]
 mem_we     out  1              activation memory write strobe
 mem_addr   out  WADDR_W        word address
 mem_wdata  out  MEM_DW         packed word: even row low half, odd row high half
 busy       out  1              high from accepted start until done
 done       out  1              one-cycle pulse after final word written

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE.
REQ-005 IDLE -> RUN on start; captures layer_sel and shamt into registers held constant for the layer.
REQ-006 start SHALL be ignored in RUN and DONE.
REQ-007 in_ready SHALL equal (state==RUN); no combinational path from in_valid to in_ready.
REQ-008 Per element: q = acc >>> shamt; q<0 -> 0; q>2^N-1 -> 2^N-1; else q[N-1:0] (ReLU + unsigned saturation).
REQ-009 Row counter r (0..W-1), tile_x, tile_y (0..T-1), channel ch (0..C-1) SHALL advance on each handshake, r fastest, then tile_x, tile_y, ch.
REQ-010 Handshake with r even: quantized row stored in pack register; no write.
REQ-011 Handshake with r odd at cycle t: at t+1 mem_we=1, mem_wdata={quant(row r), pack}, mem_addr=((ch*T+tile_y)*T+tile_x)*(W/2)+r/2.
REQ-012 mem_we SHALL be high exactly one cycle per word; mem_addr/mem_wdata hold last value when mem_we=0.
REQ-013 Handshake on final row (r=W-1, tile_x=tile_y=T-1, ch=C-1) SHALL move RUN -> DONE; in DONE, mem_we=1 for the final word and done=1 in the same cycle; DONE -> IDLE next cycle.
REQ-014 busy SHALL be high in RUN and DONE, low in IDLE.
REQ-015 Total writes per layer SHALL be T*T*C*W/2 (C1: 384, C2: 128); addresses strictly incrementing from 0.
REQ-016 Gaps in in_valid SHALL not alter counters or pack register.

Reset
REQ-017 rst SHALL asynchronously force IDLE, clear all counters and pack register; in_ready, mem_we, busy, done = 0; mem_addr, mem_wdata = 0.
REQ-018 rst asserted mid-layer SHALL abort with no further writes and no done pulse; next start begins at address 0.

Structure
REQ-019 globals_sv SHALL add ACC_W = N+BG, MEM_DW = 2*W*N, WADDR_W = $clog2(NB_TILE*NB_TILE*NB_TILEC*W/2), and the FSM state enum type.
REQ-020 Per-element shift/ReLU/saturate SHALL be a sub-module ofmap_quant, instantiated W times (combinational).

Verification
REQ-021 Reset then start, layer_sel=1, in_valid held high -> 128 writes, addresses 0..127, done pulse one cycle after final handshake, busy then low.
REQ-022 layer_sel=0, shamt=0, all accumulators = 1 -> 384 writes, every mem_wdata = 32'h5555_5555, last addr 383.
REQ-023 shamt=2, accumulators {-128, -1, 0, 3, 4, 11, 12, 127} -> quantized {0,0,0,0,1,2,3,3}, saturation at 3.
REQ-024 in_valid toggling 1-0-1 randomly -> identical write sequence and data as REQ-021; start pulsed during RUN ignored.
REQ-025 rst asserted after 37 writes in layer C1 -> outputs 0 immediately; new start yields first write at addr 0, no spurious done.
REQ-026 Even row handshake then stall 10 cycles before odd row -> single write containing both rows, pack half preserved.
